// File: rtl/mips_control_ws.sv
// Multicycle MIPS control FSM with parametrised memory wait states,
// stall gating, retired-instruction counter and an absorbing error state.
module mips_control_ws #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op_code,
  input  logic [5:0]          funct,
  input  logic                stall,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                EQorNE,
  output logic                Error,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [1:0]          RegDst,
  output logic [1:0]          MemtoReg,
  output logic [2:0]          ALUOp,
  output logic [4:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] FN_JR     = 6'h08;

  localparam logic [2:0] MIPS_AND    = 3'd0;
  localparam logic [2:0] MIPS_OR     = 3'd1;
  localparam logic [2:0] MIPS_ADD    = 3'd2;
  localparam logic [2:0] MIPS_XOR    = 3'd3;
  localparam logic [2:0] MIPS_R_TYPE = 3'd4;
  localparam logic [2:0] MIPS_SUB    = 3'd6;
  localparam logic [2:0] MIPS_SLT    = 3'd7;

  typedef enum logic [4:0] {
    S_FETCH     = 5'd0,
    S_LATCH     = 5'd1,
    S_DECODE    = 5'd2,
    S_EXEC_R    = 5'd3,
    S_WB_R      = 5'd4,
    S_EXEC_I    = 5'd5,
    S_WB_I      = 5'd6,
    S_MEM_ADDR  = 5'd7,
    S_MEM_READ  = 5'd8,
    S_MEM_WB    = 5'd9,
    S_MEM_WRITE = 5'd10,
    S_EXEC_J    = 5'd11,
    S_EXEC_JR   = 5'd12,
    S_EXEC_JAL  = 5'd13,
    S_BRANCH    = 5'd14,
    S_ERROR     = 5'd31
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_c;
  logic             wait_done_c;
  logic             is_wait_c;

  assign state       = state_q;
  assign wait_done_c = (cnt_q == CNT_LAST);
  assign is_wait_c   = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                       (state_q == S_MEM_WRITE);

  // State, wait counter and retired counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (retire_c) retired <= retired + RETIRE_W'(1);
    end
  end

  // Next-state, wait counter and Moore output decode with stall gating
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retire_c    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    EQorNE      = 1'b1;
    Error       = 1'b0;
    ALUSrcB     = 2'b01;
    PCSource    = 2'b00;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUOp       = MIPS_ADD;

    case (state_q)
      S_FETCH: begin
        if (wait_done_c) state_d = S_LATCH;
      end
      S_LATCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op_code)
          OP_R_TYPE:                                   state_d = (funct == FN_JR) ? S_EXEC_JR : S_EXEC_R;
          OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_ADDI:  state_d = S_EXEC_I;
          OP_LW, OP_SW:                                state_d = S_MEM_ADDR;
          OP_J:                                        state_d = S_EXEC_J;
          OP_JAL:                                      state_d = S_EXEC_JAL;
          OP_BEQ, OP_BNE:                              state_d = S_BRANCH;
          default:                                     state_d = S_ERROR;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        ALUOp   = MIPS_R_TYPE;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_code)
          OP_ANDI: ALUOp = MIPS_AND;
          OP_ORI:  ALUOp = MIPS_OR;
          OP_XORI: ALUOp = MIPS_XOR;
          OP_SLTI: ALUOp = MIPS_SLT;
          default: ALUOp = MIPS_ADD;
        endcase
        state_d = S_WB_I;
      end
      S_WB_I: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_code)
          OP_LW:   state_d = S_MEM_READ;
          OP_SW:   state_d = S_MEM_WRITE;
          default: state_d = S_ERROR;
        endcase
      end
      S_MEM_READ: begin
        IorD = 1'b1;
        if (wait_done_c) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (wait_done_c) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_EXEC_J: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_EXEC_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_EXEC_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b00;
        ALUOp       = MIPS_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        EQorNE      = (op_code != OP_BNE);
        state_d     = S_FETCH;
        retire_c    = 1'b1;
      end
      S_ERROR: begin
        Error = 1'b1;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    // Stall freezes progress and suppresses every write enable
    if (stall && (state_q != S_ERROR)) begin
      state_d     = state_q;
      retire_c    = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end

    // Counter restarts on every state change and counts only in wait states
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (!stall && is_wait_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_control_ws.sv
// Directed bench for mips_control_ws: three instances (L=1, L=3, L=2/4-bit counter).
module tb_mips_control_ws;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [2:0] A_AND = 3'd0;
  localparam logic [2:0] A_OR  = 3'd1;
  localparam logic [2:0] A_ADD = 3'd2;
  localparam logic [2:0] A_XOR = 3'd3;
  localparam logic [2:0] A_RT  = 3'd4;
  localparam logic [2:0] A_SUB = 3'd6;
  localparam logic [2:0] A_SLT = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op_code, funct;
  logic       stall;
  int         sel;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic       pcw [3], pcwc [3], iord [3], mw [3], irw [3], asa [3], rw [3], eqne [3], err [3];
  logic [1:0] asb [3], pcs [3], rd [3], m2r [3];
  logic [2:0] aop [3];
  logic [4:0] st  [3];
  logic [31:0] ret [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    localparam int unsigned RW  = (g == 2) ? 4 : 32;
    logic [RW-1:0] ret_l;
    mips_control_ws #(.MEM_LATENCY(LAT), .RETIRE_W(RW)) u_dut (
      .clk(clk), .rst(rst), .op_code(op_code), .funct(funct), .stall(stall),
      .PCWrite(pcw[g]), .PCWriteCond(pcwc[g]), .IorD(iord[g]), .MemWrite(mw[g]),
      .IRWrite(irw[g]), .ALUSrcA(asa[g]), .RegWrite(rw[g]), .EQorNE(eqne[g]),
      .Error(err[g]), .ALUSrcB(asb[g]), .PCSource(pcs[g]), .RegDst(rd[g]),
      .MemtoReg(m2r[g]), .ALUOp(aop[g]), .state(st[g]), .retired(ret_l)
    );
    assign ret[g] = 32'(ret_l);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view of all 1/2/3-bit outputs of the selected instance
  function automatic logic [19:0] obs();
    return {pcw[sel], pcwc[sel], iord[sel], mw[sel], irw[sel], asa[sel], rw[sel],
            eqne[sel], err[sel], asb[sel], pcs[sel], rd[sel], m2r[sel], aop[sel]};
  endfunction

  // Expected outputs for a state (unstalled), in the same packing as obs()
  function automatic logic [19:0] exp_out(input logic [4:0] s, input logic [5:0] op);
    logic e_pcw, e_pcwc, e_iord, e_mw, e_irw, e_asa, e_rw, e_eqne, e_err;
    logic [1:0] e_asb, e_pcs, e_rd, e_m2r;
    logic [2:0] e_aop;
    e_pcw = 0; e_pcwc = 0; e_iord = 0; e_mw = 0; e_irw = 0; e_asa = 0; e_rw = 0;
    e_eqne = 1; e_err = 0; e_asb = 2'b01; e_pcs = 0; e_rd = 0; e_m2r = 0; e_aop = A_ADD;
    case (s)
      5'd1:  begin e_irw = 1; e_pcw = 1; end
      5'd2:  e_asb = 2'b11;
      5'd3:  begin e_asa = 1; e_asb = 2'b00; e_aop = A_RT; end
      5'd4:  begin e_rw = 1; e_rd = 2'b01; end
      5'd5:  begin
        e_asa = 1; e_asb = 2'b10;
        case (op)
          6'h0C:   e_aop = A_AND;
          6'h0D:   e_aop = A_OR;
          6'h0E:   e_aop = A_XOR;
          6'h0A:   e_aop = A_SLT;
          default: e_aop = A_ADD;
        endcase
      end
      5'd6:  e_rw = 1;
      5'd7:  begin e_asa = 1; e_asb = 2'b10; end
      5'd8:  e_iord = 1;
      5'd9:  begin e_rw = 1; e_m2r = 2'b01; end
      5'd10: begin e_iord = 1; e_mw = 1; end
      5'd11: begin e_pcw = 1; e_pcs = 2'b10; end
      5'd12: begin e_pcw = 1; e_pcs = 2'b11; end
      5'd13: begin e_pcw = 1; e_pcs = 2'b10; e_rw = 1; e_rd = 2'b10; e_m2r = 2'b10; end
      5'd14: begin e_asa = 1; e_asb = 2'b00; e_aop = A_SUB; e_pcwc = 1; e_pcs = 2'b01;
                   e_eqne = (op != OP_BNE); end
      5'd31: e_err = 1;
      default: ;
    endcase
    return {e_pcw, e_pcwc, e_iord, e_mw, e_irw, e_asa, e_rw, e_eqne, e_err,
            e_asb, e_pcs, e_rd, e_m2r, e_aop};
  endfunction

  // Drive one instruction from its first FETCH cycle, checking state and outputs per cycle
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int unsigned seq[$], output int mw_cnt);
    op_code = op;
    funct   = fn;
    mw_cnt  = 0;
    #1;
    foreach (seq[i]) begin
      check({tag, "_state"}, 32'(st[sel]), seq[i]);
      check({tag, "_outs"}, 32'(obs()), 32'(exp_out(5'(seq[i]), op)));
      if (mw[sel]) mw_cnt++;
      tick();
    end
  endtask

  // Assert reset for one edge, checking immediate reset state, then release
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_rst_state"}, 32'(st[sel]), 0);
    check({tag, "_rst_outs"}, 32'(obs()), 32'(exp_out(5'd0, 6'h00)));
    check({tag, "_rst_retired"}, ret[sel], 0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int unsigned q[$];
    int mwc;
    rst = 1'b0; op_code = 6'h00; funct = 6'h00; stall = 1'b0; sel = 0;

    // L=1: I-type, R-type, JR, branches, JAL, LW
    do_reset("l1");
    q = '{0, 1, 2, 5, 6};  run_instr("addi", OP_ADDI, 6'h00, q, mwc);
    check("addi_retired", ret[sel], 1);
    q = '{0, 1, 2, 3, 4};  run_instr("add", OP_R, FN_ADD, q, mwc);
    check("add_retired", ret[sel], 2);
    q = '{0, 1, 2, 5, 6};  run_instr("andi", OP_ANDI, 6'h00, q, mwc);
    q = '{0, 1, 2, 12};    run_instr("jr", OP_R, FN_JR, q, mwc);
    q = '{0, 1, 2, 14};    run_instr("bne", OP_BNE, 6'h00, q, mwc);
    q = '{0, 1, 2, 14};    run_instr("beq", OP_BEQ, 6'h00, q, mwc);
    q = '{0, 1, 2, 13};    run_instr("jal", OP_JAL, 6'h00, q, mwc);
    q = '{0, 1, 2, 7, 8, 9}; run_instr("lw1", OP_LW, 6'h00, q, mwc);
    check("l1_retired", ret[sel], 8);

    // Illegal opcode: absorbing ERROR, reset exits asynchronously
    do_reset("err");
    q = '{0, 1, 2, 31};    run_instr("ill", 6'h3F, 6'h00, q, mwc);
    for (int i = 0; i < 20; i++) begin
      check("err_hold_state", 32'(st[sel]), 31);
      check("err_hold_flag", 32'(err[sel]), 1);
      check("err_hold_retired", ret[sel], 0);
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    check("err_async_state", 32'(st[sel]), 0);
    check("err_async_flag", 32'(err[sel]), 0);
    tick();
    rst = 1'b1;

    // L=3: LW 10 cycles, SW with MemWrite for 3 cycles
    sel = 1;
    do_reset("l3");
    q = '{0, 0, 0, 1, 2, 7, 8, 8, 8, 9};  run_instr("lw3", OP_LW, 6'h00, q, mwc);
    check("lw3_retired", ret[sel], 1);
    q = '{0, 0, 0, 1, 2, 7, 10, 10, 10};  run_instr("sw3", OP_SW, 6'h00, q, mwc);
    check("sw3_memwrite_cycles", 32'(mwc), 3);
    check("sw3_retired", ret[sel], 2);
    check("sw3_next_state", 32'(st[sel]), 0);

    // L=2: stall during the last MEM_WRITE cycle
    sel = 2;
    do_reset("l2");
    q = '{0, 0, 1, 2, 7};  run_instr("sw2", OP_SW, 6'h00, q, mwc);
    check("sw2_w0_state", 32'(st[sel]), 10);
    check("sw2_w0_memwrite", 32'(mw[sel]), 1);
    if (mw[sel]) mwc++;
    tick();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("stall_state", 32'(st[sel]), 10);
      check("stall_memwrite", 32'(mw[sel]), 0);
      check("stall_iord", 32'(iord[sel]), 1);
      check("stall_retired", ret[sel], 0);
      if (mw[sel]) mwc++;
      tick();
    end
    stall = 1'b0;
    #1;
    check("sw2_w1_state", 32'(st[sel]), 10);
    check("sw2_w1_memwrite", 32'(mw[sel]), 1);
    if (mw[sel]) mwc++;
    tick();
    check("sw2_memwrite_cycles", 32'(mwc), 2);
    check("sw2_done_state", 32'(st[sel]), 0);
    check("sw2_retired", ret[sel], 1);

    // 4-bit retired counter wraps after 16 instructions
    do_reset("wrap");
    for (int j = 0; j < 17; j++) begin
      q = '{0, 0, 1, 2, 11};
      run_instr("j", OP_J, 6'h00, q, mwc);
      if (j == 14) check("wrap_15", ret[sel], 15);
      if (j == 15) check("wrap_0", ret[sel], 0);
    end
    check("wrap_1", ret[sel], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
